// File: rtl/uart_cmd_parser_if.sv
// Handshake and register-bus bundle between the command parser and its neighbours.
// master = parser side; slave = UART RX/TX, register file and test environment side.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;
    logic       cmd_error;
    logic       overrun;

    modport master (
        input  rx_data, rx_valid, reg_rdata, resp_ready,
        output reg_addr, reg_wdata, reg_we, reg_re, resp_data, resp_valid, cmd_error, overrun
    );

    modport slave (
        output rx_data, rx_valid, reg_rdata, resp_ready,
        input  reg_addr, reg_wdata, reg_we, reg_re, resp_data, resp_valid, cmd_error, overrun
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII register command parser: "Whhdd<EOL>" writes, "Rhh<EOL>" reads, replies "K", "hh" or "E"
// on a valid/ready byte stream. Partial commands are aborted after TIMEOUT_CYCLES idle cycles.
module uart_cmd_parser #(
    parameter int unsigned CLOCK_FREQ     = 48_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLOCK_FREQ,
    parameter logic [7:0]  EOL_CHAR       = 8'h0A
) (
    input logic               clk,
    input logic               reset_n,
    uart_cmd_parser_if.master bus
);

    typedef enum logic [3:0] {
        StIdle,
        StWAh,
        StWAl,
        StWDh,
        StWDl,
        StRAh,
        StRAl,
        StEol,
        StDiscard,
        StExec,
        StRdWait,
        StErrResp,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      addr_sh_q, addr_sh_d;
    logic [7:0]      data_sh_q, data_sh_d;
    logic            is_write_q, is_write_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic [2:0][7:0] resp_buf_q, resp_buf_d;
    logic [1:0]      resp_len_q, resp_len_d;
    logic [1:0]      resp_idx_q, resp_idx_d;
    logic            overrun_q, overrun_d;
    logic [31:0]     cnt_q, cnt_d;

    logic       rx_cr, rx_eol, rx_hex, rx_take;
    logic [3:0] rx_nib;
    state_e     idle_next;
    logic       in_parse, busy, timeout_hit, timeout_err;

    function automatic logic is_parse(input state_e s);
        return s inside {StWAh, StWAl, StWDh, StWDl, StRAh, StRAl, StEol, StDiscard};
    endfunction

    function automatic state_e dig_next(input state_e adv, input logic eol, input logic hex);
        if (eol) return StErrResp;
        if (!hex) return StDiscard;
        return adv;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
    endfunction

    assign rx_cr   = (bus.rx_data == 8'h0D);
    assign rx_eol  = (bus.rx_data == EOL_CHAR);
    assign rx_take = bus.rx_valid && !rx_cr;
    assign rx_hex  = (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) ||
                     (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66);
    // Letters have bit 6 set and low nibble 1..6 for both cases.
    assign rx_nib  = bus.rx_data[6] ? (bus.rx_data[3:0] + 4'd9) : bus.rx_data[3:0];

    always_comb begin
        idle_next = StDiscard;
        if (bus.rx_data == 8'h57) begin
            idle_next = StWAh;
        end else if (bus.rx_data == 8'h52) begin
            idle_next = StRAh;
        end else if (rx_cr || rx_eol) begin
            idle_next = StIdle;
        end
    end

    assign in_parse    = is_parse(state_q);
    assign busy        = state_q inside {StExec, StRdWait, StErrResp, StResp};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_parse && (cnt_q >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        is_write_d  = is_write_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        resp_buf_d  = resp_buf_q;
        resp_len_d  = resp_len_q;
        resp_idx_d  = resp_idx_q;
        overrun_d   = overrun_q;
        timeout_err = 1'b0;

        if (busy && bus.rx_valid) begin
            overrun_d = 1'b1;
        end

        // An expiring timeout aborts silently; a byte in the same cycle starts a fresh command.
        if (timeout_hit) begin
            timeout_err = 1'b1;
            state_d     = bus.rx_valid ? idle_next : StIdle;
            if (bus.rx_valid) begin
                is_write_d = (bus.rx_data == 8'h57);
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_valid) begin
                        state_d    = idle_next;
                        is_write_d = (bus.rx_data == 8'h57);
                    end
                end
                StWAh: if (rx_take) begin
                    state_d        = dig_next(StWAl, rx_eol, rx_hex);
                    addr_sh_d[7:4] = rx_nib;
                end
                StWAl: if (rx_take) begin
                    state_d        = dig_next(StWDh, rx_eol, rx_hex);
                    addr_sh_d[3:0] = rx_nib;
                end
                StWDh: if (rx_take) begin
                    state_d        = dig_next(StWDl, rx_eol, rx_hex);
                    data_sh_d[7:4] = rx_nib;
                end
                StWDl: if (rx_take) begin
                    state_d        = dig_next(StEol, rx_eol, rx_hex);
                    data_sh_d[3:0] = rx_nib;
                end
                StRAh: if (rx_take) begin
                    state_d        = dig_next(StRAl, rx_eol, rx_hex);
                    addr_sh_d[7:4] = rx_nib;
                end
                StRAl: if (rx_take) begin
                    state_d        = dig_next(StEol, rx_eol, rx_hex);
                    addr_sh_d[3:0] = rx_nib;
                end
                StEol: if (rx_take) begin
                    if (rx_eol) begin
                        state_d    = StExec;
                        reg_addr_d = addr_sh_q;
                        if (is_write_q) begin
                            reg_wdata_d = data_sh_q;
                        end
                    end else begin
                        state_d = StDiscard;
                    end
                end
                StDiscard: if (rx_take && rx_eol) begin
                    state_d = StErrResp;
                end
                StExec: begin
                    if (is_write_q) begin
                        state_d       = StResp;
                        resp_buf_d[0] = 8'h4B;
                        resp_buf_d[1] = EOL_CHAR;
                        resp_len_d    = 2'd2;
                        resp_idx_d    = 2'd0;
                    end else begin
                        state_d = StRdWait;
                    end
                end
                StRdWait: begin
                    state_d       = StResp;
                    resp_buf_d[0] = hex_chr(bus.reg_rdata[7:4]);
                    resp_buf_d[1] = hex_chr(bus.reg_rdata[3:0]);
                    resp_buf_d[2] = EOL_CHAR;
                    resp_len_d    = 2'd3;
                    resp_idx_d    = 2'd0;
                end
                StErrResp: begin
                    state_d       = StResp;
                    resp_buf_d[0] = 8'h45;
                    resp_buf_d[1] = EOL_CHAR;
                    resp_len_d    = 2'd2;
                    resp_idx_d    = 2'd0;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        if (resp_idx_q == resp_len_q - 2'd1) begin
                            state_d    = StIdle;
                            resp_idx_d = 2'd0;
                        end else begin
                            resp_idx_d = resp_idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Counts cycles since the last accepted byte; CR neither restarts nor pauses it.
    always_comb begin
        if (TIMEOUT_CYCLES == 0 || !is_parse(state_d)) begin
            cnt_d = '0;
        end else if (rx_take) begin
            cnt_d = 32'd1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            is_write_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            resp_buf_q  <= '0;
            resp_len_q  <= '0;
            resp_idx_q  <= '0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            is_write_q  <= is_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            resp_buf_q  <= resp_buf_d;
            resp_len_q  <= resp_len_d;
            resp_idx_q  <= resp_idx_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.reg_we     = (state_q == StExec) && is_write_q;
    assign bus.reg_re     = (state_q == StExec) && !is_write_q;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_data  = (state_q == StResp) ? resp_buf_q[resp_idx_q] : 8'h00;
    assign bus.cmd_error  = (state_q == StErrResp) || timeout_err;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: commands, malformed input, timeout, backpressure, reset.
module tb_uart_cmd_parser;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int         cyc = 0;
    int         we_cnt = 0, we_cyc = 0, re_cnt = 0, re_cyc = 0;
    int         err_cnt = 0, err_cyc = 0, vld_cyc = 0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
    logic       vld_prev = 1'b0;
    logic [7:0] rsp_q[$];
    logic [7:0] rd_val = 8'h00;

    int last_cyc = 0;
    int b_we = 0, b_re = 0, b_err = 0, b_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data is present only in the cycle after reg_re.
    always @(posedge clk) bus.reg_rdata <= bus.reg_re ? rd_val : 8'h00;

    always @(negedge clk) begin
        if (bus.reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_cyc  <= cyc;
            we_addr <= bus.reg_addr;
            we_data <= bus.reg_wdata;
        end
        if (bus.reg_re) begin
            re_cnt  <= re_cnt + 1;
            re_cyc  <= cyc;
            re_addr <= bus.reg_addr;
        end
        if (bus.cmd_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (bus.resp_valid && !vld_prev) vld_cyc <= cyc;
        vld_prev <= bus.resp_valid;
        if (bus.resp_valid && bus.resp_ready) rsp_q.push_back(bus.resp_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_we  = we_cnt;
        b_re  = re_cnt;
        b_err = err_cnt;
        b_rsp = rsp_q.size();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_cyc     = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_rsp(input string tag, input int n, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp [3];
        exp[0] = e0;
        exp[1] = e1;
        exp[2] = e2;
        check_eq({tag, "_len"}, rsp_q.size() - b_rsp, n);
        for (int i = 0; i < n; i++) begin
            if (b_rsp + i < rsp_q.size()) begin
                check_eq({tag, "_byte"}, {24'h0, rsp_q[b_rsp + i]}, {24'h0, exp[i]});
            end else begin
                check_eq({tag, "_missing"}, 32'h1, 32'h0);
            end
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
        check_eq("resp_valid_seen", bus.resp_valid, 1);
    endtask

    initial begin
        logic stable;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_resp_valid", bus.resp_valid, 0);
        check_eq("rst_strobes", {bus.reg_we, bus.reg_re, bus.cmd_error, bus.overrun}, 0);
        check_eq("rst_regs", {bus.reg_addr, bus.reg_wdata, bus.resp_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Write
        mark();
        send_str("W3Ca5\n");
        repeat (10) @(posedge clk);
        check_eq("wr_we_cnt", we_cnt - b_we, 1);
        check_eq("wr_we_lat", we_cyc - last_cyc, 1);
        check_eq("wr_addr", we_addr, 8'h3C);
        check_eq("wr_data", we_data, 8'hA5);
        check_eq("wr_rsp_lat", vld_cyc - last_cyc, 2);
        check_rsp("wr_rsp", 2, 8'h4B, 8'h0A, 8'h00);
        check_eq("wr_err", err_cnt - b_err, 0);
        check_eq("wr_addr_hold", bus.reg_addr, 8'h3C);

        // Read
        rd_val = 8'h7F;
        mark();
        send_str("R10\n");
        repeat (12) @(posedge clk);
        check_eq("rd_re_cnt", re_cnt - b_re, 1);
        check_eq("rd_re_lat", re_cyc - last_cyc, 1);
        check_eq("rd_addr", re_addr, 8'h10);
        check_eq("rd_rsp_lat", vld_cyc - last_cyc, 3);
        check_rsp("rd_rsp", 3, 8'h37, 8'h46, 8'h0A);
        check_eq("rd_we", we_cnt - b_we, 0);

        // Bad hex digit
        mark();
        send_str("WG1\n");
        repeat (10) @(posedge clk);
        check_eq("badhex_we", we_cnt - b_we, 0);
        check_eq("badhex_err", err_cnt - b_err, 1);
        check_eq("badhex_err_lat", err_cyc - last_cyc, 1);
        check_eq("badhex_rsp_lat", vld_cyc - last_cyc, 2);
        check_rsp("badhex_rsp", 2, 8'h45, 8'h0A, 8'h00);

        // Short command
        mark();
        send_str("R1\n");
        repeat (10) @(posedge clk);
        check_eq("short_re", re_cnt - b_re, 0);
        check_eq("short_err", err_cnt - b_err, 1);
        check_rsp("short_rsp", 2, 8'h45, 8'h0A, 8'h00);

        // CR and blank lines in IDLE
        mark();
        send_byte(8'h0D);
        send_str("\n\n");
        repeat (10) @(posedge clk);
        check_eq("blank_err", err_cnt - b_err, 0);
        check_eq("blank_strobes", (we_cnt - b_we) + (re_cnt - b_re), 0);
        check_rsp("blank_rsp", 0, 8'h00, 8'h00, 8'h00);

        // Timeout after a partial command
        mark();
        send_str("W1");
        repeat (120) @(posedge clk);
        check_eq("to_err", err_cnt - b_err, 1);
        check_eq("to_err_lat", err_cyc - last_cyc, 99);
        check_eq("to_we", we_cnt - b_we, 0);
        check_rsp("to_rsp", 0, 8'h00, 8'h00, 8'h00);
        rd_val = 8'h5A;
        mark();
        send_str("R00\n");
        repeat (12) @(posedge clk);
        check_eq("to_next_re", re_cnt - b_re, 1);
        check_rsp("to_next_rsp", 3, 8'h35, 8'h41, 8'h0A);

        // Backpressure with a byte dropped while busy
        bus.resp_ready = 1'b0;
        rd_val = 8'hC3;
        mark();
        send_str("R00\n");
        wait_valid();
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_data !== 8'h43) stable = 1'b0;
            if (i == 20) begin
                bus.rx_data  = 8'h58;
                bus.rx_valid = 1'b1;
            end
            if (i == 21) bus.rx_valid = 1'b0;
        end
        check_eq("bp_stable", stable, 1);
        check_eq("bp_overrun", bus.overrun, 1);
        bus.resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        check_rsp("bp_rsp", 3, 8'h43, 8'h33, 8'h0A);
        check_eq("bp_overrun_sticky", bus.overrun, 1);
        check_eq("bp_err", err_cnt - b_err, 0);

        // Reset while a response is pending
        bus.resp_ready = 1'b0;
        rd_val = 8'h99;
        mark();
        send_str("R20\n");
        wait_valid();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_resp_valid", bus.resp_valid, 0);
        check_eq("mrst_strobes", {bus.reg_we, bus.reg_re, bus.cmd_error, bus.overrun}, 0);
        check_eq("mrst_regs", {bus.reg_addr, bus.reg_wdata, bus.resp_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.resp_ready = 1'b1;
        check_rsp("mrst_lost", 0, 8'h00, 8'h00, 8'h00);
        mark();
        send_str("W0001\n");
        repeat (10) @(posedge clk);
        check_eq("mrst_we_cnt", we_cnt - b_we, 1);
        check_eq("mrst_addr", we_addr, 8'h00);
        check_eq("mrst_data", we_data, 8'h01);
        check_rsp("mrst_rsp", 2, 8'h4B, 8'h0A, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
